// File: rtl/cmos_nvram_pkg.sv
// Shared types and default widths for the CMOS NVRAM arbiter.
package cmos_nvram_pkg;

  localparam int unsigned DEF_ADDR_W = 10;  // 1K CMOS locations
  localparam int unsigned DEF_DATA_W = 4;   // nibble-wide CMOS RAM
  localparam int unsigned DEF_HPS_W  = 8;   // HPS ioctl byte

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    HPS_WR = 2'd2,
    HPS_RD = 2'd3
  } state_t;

  typedef enum logic {
    PK_WR = 1'b0,
    PK_RD = 1'b1
  } pend_kind_t;

endpackage

// File: rtl/cmos_nvram_arbiter.sv
// Shares the single-port CMOS RAM between the game CPU and the HPS ioctl
// save/load path. CPU accesses always win; a one-entry buffer holds a single
// HPS byte access until a free slot. CPU writes raise a dirty flag for autosave.
//
// Ports:
//   clock_12, reset_n           clock and synchronous active-low reset
//   cpu_ce/we/addr/din, cpu_dout CPU access strobe and read data (2 cycles)
//   dn_active, dn_wr/addr/data  HPS load: hold CPU, byte writes
//   up_rd/addr, up_data/ack     HPS save: byte read request and response
//   cpu_hold                    keeps CPU in reset while loading
//   dirty, dirty_clr            CPU-wrote-since-last-save flag and its clear
//   mem_addr/we/din, mem_dout   RAM port (combinational drive, 1-cycle read)
module cmos_nvram_arbiter
  import cmos_nvram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned HPS_W  = DEF_HPS_W
) (
  input  logic              clock_12,
  input  logic              reset_n,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              dn_active,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [HPS_W-1:0]  dn_data,
  input  logic              up_rd,
  input  logic [ADDR_W-1:0] up_addr,
  output logic [HPS_W-1:0]  up_data,
  output logic              up_ack,
  output logic              cpu_hold,
  output logic              dirty,
  input  logic              dirty_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned PAD_W = HPS_W - DATA_W;

  state_t              state;
  state_t              state_nxt;
  logic                cpu_acc_c;
  logic                cpu_wr_acc_c;
  logic                pend_clr_c;
  logic                pend_full;
  pend_kind_t          pend_kind;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;
  logic                unused_pad;

  // Padding bits of the HPS write byte are intentionally discarded.
  assign unused_pad = ^dn_data[HPS_W-1:DATA_W];

  // CPU strobes are ignored while the CPU is held for a load.
  assign cpu_acc_c    = cpu_ce & ~cpu_hold;
  assign cpu_wr_acc_c = (state == IDLE) & cpu_acc_c & cpu_we;

  // State register.
  always_ff @(posedge clock_12) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and RAM port drive; reset forces the port quiet.
  always_comb begin
    state_nxt  = state;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_din    = '0;
    pend_clr_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_acc_c) begin
          mem_addr = cpu_addr;
          if (cpu_we) begin
            mem_we  = 1'b1;
            mem_din = cpu_din;
          end else begin
            state_nxt = CPU_RD;
          end
        end else if (pend_full) begin
          mem_addr = pend_addr;
          if (pend_kind == PK_WR) begin
            mem_we    = 1'b1;
            mem_din   = pend_data;
            state_nxt = HPS_WR;
          end else begin
            state_nxt = HPS_RD;
          end
        end
      end
      CPU_RD: begin
        state_nxt = IDLE;
      end
      HPS_WR: begin
        pend_clr_c = 1'b1;
        state_nxt  = IDLE;
      end
      HPS_RD: begin
        pend_clr_c = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!reset_n) begin
      state_nxt  = IDLE;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_din    = '0;
      pend_clr_c = 1'b0;
    end
  end

  // Read-data capture, HPS response, hold and dirty tracking.
  always_ff @(posedge clock_12) begin
    if (!reset_n) begin
      cpu_dout <= '0;
      up_data  <= '0;
      up_ack   <= 1'b0;
      cpu_hold <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      cpu_hold <= dn_active;
      up_ack   <= 1'b0;
      if (state == CPU_RD) begin
        cpu_dout <= mem_dout;
      end
      if (state == HPS_RD) begin
        up_data <= HPS_W'({{PAD_W{1'b1}}, mem_dout});
        up_ack  <= 1'b1;
      end
      // A coincident clear loses to a CPU write.
      if (cpu_wr_acc_c) begin
        dirty <= 1'b1;
      end else if (dirty_clr) begin
        dirty <= 1'b0;
      end
    end
  end

  // One-entry HPS buffer; strobes arriving while it is full are dropped.
  always_ff @(posedge clock_12) begin
    if (!reset_n) begin
      pend_full <= 1'b0;
      pend_kind <= PK_WR;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (pend_clr_c) begin
      pend_full <= 1'b0;
    end else if (!pend_full) begin
      if (dn_wr) begin
        pend_full <= 1'b1;
        pend_kind <= PK_WR;
        pend_addr <= dn_addr;
        pend_data <= dn_data[DATA_W-1:0];
      end else if (up_rd) begin
        pend_full <= 1'b1;
        pend_kind <= PK_RD;
        pend_addr <= up_addr;
      end
    end
  end

  // CPU accesses must only arrive while the arbiter is idle.
  always_ff @(posedge clock_12) begin
    if (reset_n) begin
      assert (!(cpu_acc_c && (state != IDLE)))
        else $error("cmos_nvram_arbiter: cpu access while arbiter busy");
    end
  end

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Directed bench for cmos_nvram_arbiter with a behavioural registered RAM,
// a shadow memory model and expected-result queues.
module tb_cmos_nvram_arbiter;
  import cmos_nvram_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 4;
  localparam int unsigned HW = 8;

  logic          clock_12 = 1'b0;
  logic          reset_n;
  logic          cpu_ce, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic          dn_active, dn_wr;
  logic [AW-1:0] dn_addr;
  logic [HW-1:0] dn_data;
  logic          up_rd;
  logic [AW-1:0] up_addr;
  logic [HW-1:0] up_data;
  logic          up_ack, cpu_hold, dirty, dirty_clr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] ram    [1024];
  logic [DW-1:0] shadow [1024];
  logic [HW-1:0] exp_up [$];
  logic [DW-1:0] exp_cpu[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int lat_idle, lat_cont, lat_tmp, start_cnt, c0;

  cmos_nvram_arbiter dut (
    .clock_12 (clock_12), .reset_n (reset_n),
    .cpu_ce (cpu_ce), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
    .cpu_din (cpu_din), .cpu_dout (cpu_dout),
    .dn_active (dn_active), .dn_wr (dn_wr), .dn_addr (dn_addr), .dn_data (dn_data),
    .up_rd (up_rd), .up_addr (up_addr), .up_data (up_data), .up_ack (up_ack),
    .cpu_hold (cpu_hold), .dirty (dirty), .dirty_clr (dirty_clr),
    .mem_addr (mem_addr), .mem_we (mem_we), .mem_din (mem_din), .mem_dout (mem_dout)
  );

  always #5 clock_12 = ~clock_12;

  always @(posedge clock_12) cyc <= cyc + 1;

  // Registered single-port RAM, read-before-write.
  always @(posedge clock_12) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // HPS response monitor: every up_ack pops one expected byte.
  always @(negedge clock_12) begin
    if (up_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (exp_up.size() == 0) chk("unexpected_up_ack", 32'(up_ack), 32'h0);
      else chk("up_data", 32'(up_data), 32'(exp_up.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    #1;
    chk("cpu_wr_mem_we", 32'(mem_we), 32'h1);
    chk("cpu_wr_mem_addr", 32'(mem_addr), 32'(a));
    chk("cpu_wr_mem_din", 32'(mem_din), 32'(d));
    shadow[a] = d;
    tick();
    cpu_ce = 1'b0; cpu_we = 1'b0;
    #1;
    chk("cpu_wr_we_one_cycle", 32'(mem_we), 32'h0);
    tick();
    tick();
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    exp_cpu.push_back(shadow[a]);
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_ce = 1'b0;
    tick();
    chk("cpu_dout", 32'(cpu_dout), 32'(exp_cpu.pop_front()));
    tick();
  endtask

  task automatic hps_write(input logic [AW-1:0] a, input logic [HW-1:0] d);
    shadow[a] = d[DW-1:0];
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    tick();
    dn_wr = 1'b0;
    repeat (4) tick();
  endtask

  // Waits a bounded number of cycles for the next up_ack; returns latency.
  task automatic wait_ack(input int cstart, input int astart, output int lat);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (ack_cnt != astart) break;
      tick();
    end
    if (ack_cnt == astart) chk("up_ack_timeout", 32'h0, 32'h1);
    else lat = ack_cyc - cstart;
  endtask

  task automatic hps_read(input logic [AW-1:0] a, output int lat);
    int cs, as;
    cs = cyc;
    as = ack_cnt;
    exp_up.push_back(HW'({4'hF, shadow[a]}));
    up_rd = 1'b1; up_addr = a;
    tick();
    up_rd = 1'b0;
    wait_ack(cs, as, lat);
    chk("hps_rd_latency_le4", 32'(lat >= 1 && lat <= 4), 32'h1);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    dn_active = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    up_rd = 1'b0; up_addr = '0; dirty_clr = 1'b0;
    repeat (3) tick();

    chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("rst_up_data", 32'(up_data), 32'h0);
    chk("rst_up_ack", 32'(up_ack), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_din", 32'(mem_din), 32'h0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'h0);
    reset_n = 1'b1;
    tick();

    // CPU write then read back.
    cpu_write(10'h3A5, 4'h7);
    chk("dirty_after_cpu_wr", 32'(dirty), 32'h1);
    cpu_read(10'h3A5);

    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    chk("dirty_clr_alone", 32'(dirty), 32'h0);

    // HPS load with CPU held.
    dn_active = 1'b1;
    tick();
    chk("cpu_hold_set", 32'(cpu_hold), 32'h1);
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3A5; cpu_din = 4'h2;
    #1;
    chk("held_cpu_ignored", 32'(mem_we), 32'h0);
    tick();
    cpu_ce = 1'b0; cpu_we = 1'b0;
    hps_write(10'h010, 8'hC9);
    chk("ram_after_dn_wr", 32'(ram[10'h010]), 32'h9);
    chk("dirty_not_set_by_hps", 32'(dirty), 32'h0);
    dn_active = 1'b0;
    tick();
    chk("cpu_hold_release", 32'(cpu_hold), 32'h0);

    hps_read(10'h010, lat_idle);
    hps_read(10'h3A5, lat_tmp);

    // CPU read and HPS read strobed together: CPU first.
    c0 = cyc;
    start_cnt = ack_cnt;
    exp_cpu.push_back(shadow[10'h3A5]);
    exp_up.push_back(HW'({4'hF, shadow[10'h010]}));
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3A5;
    up_rd = 1'b1; up_addr = 10'h010;
    tick();
    cpu_ce = 1'b0; up_rd = 1'b0;
    tick();
    chk("contended_cpu_dout", 32'(cpu_dout), 32'(exp_cpu.pop_front()));
    wait_ack(c0, start_cnt, lat_cont);
    chk("contended_hps_delayed", 32'(lat_cont > lat_idle && lat_cont <= lat_idle + 2), 32'h1);
    repeat (3) tick();

    // Second HPS write while the buffer is full is dropped.
    hps_write(10'h020, 8'h05);
    shadow[10'h030] = 4'h3;
    dn_wr = 1'b1; dn_addr = 10'h030; dn_data = 8'hA3;
    tick();
    dn_addr = 10'h020; dn_data = 8'h0A;
    tick();
    dn_wr = 1'b0;
    repeat (4) tick();
    chk("ram_first_wr_kept", 32'(ram[10'h030]), 32'h3);
    chk("ram_dropped_wr", 32'(ram[10'h020]), 32'h5);
    hps_read(10'h020, lat_tmp);

    // dirty_clr coincident with a CPU write: set wins.
    shadow[10'h100] = 4'hC;
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h100; cpu_din = 4'hC; dirty_clr = 1'b1;
    tick();
    cpu_ce = 1'b0; cpu_we = 1'b0; dirty_clr = 1'b0;
    chk("dirty_set_wins", 32'(dirty), 32'h1);
    tick();
    tick();
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    chk("dirty_clr_after", 32'(dirty), 32'h0);
    cpu_read(10'h100);
    cpu_write(10'h200, 4'h1);

    // Reset asserted while the arbiter is in HPS_RD.
    up_rd = 1'b1; up_addr = 10'h010;
    tick();
    up_rd = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_up_ack", 32'(up_ack), 32'h0);
    chk("midrst_up_data", 32'(up_data), 32'h0);
    chk("midrst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("midrst_dirty", 32'(dirty), 32'h0);
    chk("midrst_mem_we", 32'(mem_we), 32'h0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    hps_read(10'h010, lat_tmp);

    repeat (3) tick();
    chk("exp_up_drained", 32'(exp_up.size()), 32'h0);
    chk("exp_cpu_drained", 32'(exp_cpu.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
